// File: rtl/timing_pkg.sv
// ---------------------------------------------------------------------------
// timing_pkg
// Shared timing definitions for the beat sequencer and display logic.
//   beat_t : instruction-cycle beat codes (SCAN1, ACTION1, SCAN2, ACTION2)
//   mode_t : run-control modes (STOPPED, RUN, STEP, HALTED)
//   WORD_BITS_DEF / BO_DIGITS_DEF : default word length and black-out length
// ---------------------------------------------------------------------------
package timing_pkg;

   typedef enum logic [1:0] {
      SCAN1   = 2'd0,
      ACTION1 = 2'd1,
      SCAN2   = 2'd2,
      ACTION2 = 2'd3
   } beat_t;

   typedef enum logic [1:0] {
      M_STOPPED = 2'd0,
      M_RUN     = 2'd1,
      M_STEP    = 2'd2,
      M_HALTED  = 2'd3
   } mode_t;

   localparam int WORD_BITS_DEF = 32;
   localparam int BO_DIGITS_DEF = 4;

endpackage

// File: rtl/digit_timer.sv
// ---------------------------------------------------------------------------
// digit_timer
// Free-running digit counter 0..BEAT_LEN-1 with black-out and last-digit
// decode taken straight from the registered count.
//   clk_i      : dash clock
//   rst_i      : synchronous active-high reset (count -> 0)
//   dig_o      : current digit index
//   bo_o       : high while dig_o >= WORD_BITS (flyback window)
//   dig_last_o : high when dig_o == BEAT_LEN-1 (beat boundary)
// ---------------------------------------------------------------------------
module digit_timer #(
   parameter int WORD_BITS = 32,
   parameter int BEAT_LEN  = 36,
   parameter int DW        = 6
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic [DW-1:0] dig_o,
   output logic          bo_o,
   output logic          dig_last_o
);

   logic [DW-1:0] dig_q;
   logic [DW-1:0] dig_d;
   logic          last;

   assign last = (dig_q == DW'(BEAT_LEN - 1));

   always_comb begin
      dig_d = dig_q + 1'b1;
      if (last) begin
         dig_d = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dig_q <= '0;
      end else begin
         dig_q <= dig_d;
      end
   end

   assign dig_o      = dig_q;
   assign bo_o       = (dig_q >= DW'(WORD_BITS));
   assign dig_last_o = last;

endmodule

// File: rtl/beat_sequencer.sv
// ---------------------------------------------------------------------------
// beat_sequencer
// Central timing and run-control sequencer. A digit timer produces the digit
// index and black-out window; a four-beat instruction cycle drives HA/HS and
// the store write window; a mode FSM decides when instructions execute.
//   dashclk    : sole clock
//   reset      : synchronous active-high reset
//   run_sw     : run/stop switch level (1 = run)
//   step       : single-shot key pulse
//   halt_req   : stop instruction from the datapath (pulse or level)
//   write_req  : datapath store-write request for the current action beat
//   dig        : digit index 0..BEAT_LEN-1
//   bo         : black-out (dig >= WORD_BITS)
//   ha / hs    : action beat active / its complement
//   beat       : current beat code
//   exec       : instruction executing
//   dig_last   : dig == BEAT_LEN-1
//   store_we   : store write strobe
//   instr_done : one-cycle pulse at the end of ACTION2
//   running    : mode is RUN
//   halted     : stop lamp
// ---------------------------------------------------------------------------
module beat_sequencer
   import timing_pkg::*;
#(
   parameter  int WORD_BITS = WORD_BITS_DEF,
   parameter  int BO_DIGITS = BO_DIGITS_DEF,
   localparam int BEAT_LEN  = WORD_BITS + BO_DIGITS,
   localparam int DW        = $clog2(BEAT_LEN)
) (
   input  logic          dashclk,
   input  logic          reset,
   input  logic          run_sw,
   input  logic          step,
   input  logic          halt_req,
   input  logic          write_req,
   output logic [DW-1:0] dig,
   output logic          bo,
   output logic          ha,
   output logic          hs,
   output logic [1:0]    beat,
   output logic          exec,
   output logic          dig_last,
   output logic          store_we,
   output logic          instr_done,
   output logic          running,
   output logic          halted
);

   mode_t mode_q, mode_d;
   beat_t beat_q, beat_d;
   logic  step_lat_q, step_lat_d;
   logic  halt_lat_q, halt_lat_d;
   logic  halt_now;
   logic  action_beat;

   digit_timer #(
      .WORD_BITS (WORD_BITS),
      .BEAT_LEN  (BEAT_LEN),
      .DW        (DW)
   ) u_digit_timer (
      .clk_i      (dashclk),
      .rst_i      (reset),
      .dig_o      (dig),
      .bo_o       (bo),
      .dig_last_o (dig_last)
   );

   assign exec        = (mode_q == M_RUN) || (mode_q == M_STEP);
   assign action_beat = (beat_q == ACTION1) || (beat_q == ACTION2);
   // A halt request arriving on the ACTION2 boundary itself still counts.
   assign halt_now    = halt_lat_q | (exec & halt_req);

   always_comb begin
      mode_d     = mode_q;
      beat_d     = beat_q;
      step_lat_d = step_lat_q;
      halt_lat_d = halt_lat_q;

      if ((mode_q == M_STOPPED) && step) begin
         step_lat_d = 1'b1;
      end
      if (exec && halt_req) begin
         halt_lat_d = 1'b1;
      end

      if (dig_last) begin
         // Beat wraps ACTION2 -> SCAN1 naturally on the 2-bit increment.
         beat_d = exec ? beat_t'(beat_q + 2'd1) : SCAN1;

         unique case (mode_q)
            M_STOPPED: begin
               if (run_sw) begin
                  mode_d     = M_RUN;
                  step_lat_d = 1'b0;
               end else if (step_lat_q) begin
                  mode_d     = M_STEP;
                  step_lat_d = 1'b0;
               end
            end
            M_RUN, M_STEP: begin
               if (beat_q == ACTION2) begin
                  if (halt_now) begin
                     mode_d     = M_HALTED;
                     halt_lat_d = 1'b0;
                  end else if ((mode_q == M_STEP) || !run_sw) begin
                     mode_d = M_STOPPED;
                  end
               end
            end
            M_HALTED: begin
               if (!run_sw) begin
                  mode_d = M_STOPPED;
               end
            end
            default: mode_d = M_STOPPED;
         endcase
      end
   end

   always_ff @(posedge dashclk) begin
      if (reset) begin
         mode_q     <= M_STOPPED;
         beat_q     <= SCAN1;
         step_lat_q <= 1'b0;
         halt_lat_q <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         beat_q     <= beat_d;
         step_lat_q <= step_lat_d;
         halt_lat_q <= halt_lat_d;
      end
   end

   assign beat       = beat_q;
   assign ha         = exec & action_beat;
   assign hs         = ~ha;
   assign store_we   = exec & action_beat & ~bo & write_req;
   // Suppressed while reset is sampled so an aborted instruction never reports done.
   assign instr_done = exec & (beat_q == ACTION2) & dig_last & ~reset;
   assign running    = (mode_q == M_RUN);
   assign halted     = (mode_q == M_HALTED);

endmodule

// File: tb/tb_beat_sequencer.sv
module tb_beat_sequencer;

   localparam int WB = 32;
   localparam int BL = 36;
   localparam int ST_STOP = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_STEP = 2;
   localparam int ST_HALT = 3;

   // clock / reset
   logic dashclk = 1'b0;
   always #5 dashclk = ~dashclk;

   logic       reset = 1'b1;
   logic       run_sw = 1'b0;
   logic       step = 1'b0;
   logic       halt_req = 1'b0;
   logic       write_req = 1'b0;
   logic [5:0] dig;
   logic       bo, ha, hs, exec, dig_last, store_we, instr_done, running, halted;
   logic [1:0] beat;

   beat_sequencer dut (
      .dashclk    (dashclk),
      .reset      (reset),
      .run_sw     (run_sw),
      .step       (step),
      .halt_req   (halt_req),
      .write_req  (write_req),
      .dig        (dig),
      .bo         (bo),
      .ha         (ha),
      .hs         (hs),
      .beat       (beat),
      .exec       (exec),
      .dig_last   (dig_last),
      .store_we   (store_we),
      .instr_done (instr_done),
      .running    (running),
      .halted     (halted)
   );

   // scoreboard
   logic [16:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int cyc_n    = 0;

   // Reference model: time since reset gives the digit, cycles into the
   // current instruction give the beat.
   bit m_valid = 0;
   int m_t     = 0;
   int m_mode  = ST_STOP;
   int m_it    = 0;
   bit m_step  = 0;
   bit m_halt  = 0;

   function automatic bit m_exec();
      return (m_mode == ST_RUN) || (m_mode == ST_STEP);
   endfunction

   function automatic int m_beat();
      return m_exec() ? (m_it / BL) : 0;
   endfunction

   function automatic logic [16:0] model_out();
      int  d;
      int  b;
      bit  e;
      bit  a;
      logic [5:0] d6;
      logic [1:0] b2;
      d  = m_t % BL;
      e  = m_exec();
      b  = m_beat();
      a  = e && (b == 1 || b == 3);
      d6 = 6'(d);
      b2 = 2'(b);
      return {d6, (d >= WB), a, !a, b2, e, (d == BL - 1),
              (a && d < WB && write_req), (e && m_it == 4 * BL - 1 && !reset),
              (m_mode == ST_RUN), (m_mode == ST_HALT)};
   endfunction

   task automatic model_step();
      bit bnd;
      bit e;
      bit halt_p;
      bit step_old;
      if (reset) begin
         m_valid = 1; m_t = 0; m_mode = ST_STOP; m_it = 0; m_step = 0; m_halt = 0;
         return;
      end
      if (!m_valid) return;
      bnd      = ((m_t % BL) == BL - 1);
      e        = m_exec();
      halt_p   = m_halt | (e & halt_req);
      step_old = m_step;
      m_halt   = halt_p;
      if (m_mode == ST_STOP && step) m_step = 1;
      if (e) m_it++;
      if (bnd) begin
         case (m_mode)
            ST_STOP: begin
               if (run_sw) begin
                  m_mode = ST_RUN; m_step = 0; m_it = 0;
               end else if (step_old) begin
                  m_mode = ST_STEP; m_step = 0; m_it = 0;
               end
            end
            ST_RUN, ST_STEP: begin
               if (m_it == 4 * BL) begin
                  m_it = 0;
                  if (halt_p) begin
                     m_mode = ST_HALT; m_halt = 0;
                  end else if (m_mode == ST_STEP || !run_sw) begin
                     m_mode = ST_STOP;
                  end
               end
            end
            default: if (!run_sw) m_mode = ST_STOP;
         endcase
      end
      m_t = (m_t + 1) % BL;
   endtask

   // driver: one clock cycle with the inputs currently applied
   task automatic tick();
      if (m_valid) exp_q.push_back(model_out());
      model_step();
      @(posedge dashclk);
      #1;
      cyc_n++;
   endtask

   // bounded wait on a model position; expiry is a failed comparison
   task automatic wait_pos(input int d, input int b, input int budget, input string name);
      int n;
      n = 0;
      while (!((m_t % BL) == d && (b < 0 || (m_exec() && m_beat() == b))) && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL wait_%s: position dig=%0d beat=%0d not reached, at dig=%0d mode=%0d",
                  name, d, b, m_t % BL, m_mode);
      end
   endtask

   task automatic wait_mode(input int md, input int budget, input string name);
      int n;
      n = 0;
      while (m_mode != md && n < budget) begin
         tick();
         n++;
      end
      n_checks++;
      if (n >= budget) begin
         n_fail++;
         $display("FAIL wait_%s: model mode %0d required %0d", name, m_mode, md);
      end
   endtask

   // monitor: compare every presented output vector at the falling edge
   initial begin
      logic [16:0] ev;
      logic [16:0] av;
      forever begin
         @(negedge dashclk);
         if (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            av = {dig, bo, ha, hs, beat, exec, dig_last, store_we, instr_done, running, halted};
            n_checks++;
            if (av !== ev) begin
               n_fail++;
               $display("FAIL outputs cyc=%0d actual=%05h required=%05h (dig %0d/%0d beat %0d/%0d)",
                        cyc_n, av, ev, av[16:11], ev[16:11], av[7:6], ev[7:6]);
            end
         end
      end
   end

   // stimulus
   initial begin
      @(posedge dashclk);
      #1;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // idle: digits free-run, nothing executes even with write_req high
      write_req = 1'b1;
      repeat (72) tick();

      // single step started from dig 10
      wait_pos(10, -1, 40, "step_dig10");
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (4 * BL + 60) begin
         write_req = 1'($urandom_range(0, 1));
         tick();
      end

      // continuous run with write_req held
      run_sw    = 1'b1;
      write_req = 1'b1;
      repeat (3 * 4 * BL + 40) tick();

      // halt pulse in SCAN2 dig 5
      wait_pos(5, 2, 200, "scan2_dig5");
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      wait_mode(ST_HALT, 200, "halted");
      repeat (80) tick();
      run_sw = 1'b0;
      repeat (40) tick();
      run_sw = 1'b1;
      repeat (40) tick();

      // run switch dropped during ACTION1
      wait_pos(10, 1, 200, "action1");
      run_sw = 1'b0;
      repeat (200) tick();

      // step pulse on the same cycle as the halt-triggered HALTED entry
      run_sw = 1'b1;
      wait_pos(3, 0, 200, "scan1_dig3");
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      wait_pos(BL - 1, 3, 200, "action2_end");
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (80) tick();
      run_sw = 1'b0;
      repeat (40) tick();

      // reset during ACTION2 dig 20
      run_sw = 1'b1;
      wait_pos(20, 3, 300, "action2_dig20");
      reset = 1'b1;
      tick();
      reset  = 1'b0;
      run_sw = 1'b0;
      repeat (40) tick();

      // randomized mixed operation
      repeat (3000) begin
         if ($urandom_range(0, 149) == 0) run_sw = ~run_sw;
         step      = ($urandom_range(0, 59) == 0);
         halt_req  = ($urandom_range(0, 99) == 0);
         write_req = 1'($urandom_range(0, 1));
         reset     = ($urandom_range(0, 1499) == 0);
         tick();
      end
      reset = 1'b0; step = 1'b0; halt_req = 1'b0;
      repeat (4) tick();

      @(negedge dashclk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected vectors left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
